// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer, the RAM/data bus, the opcode decoders and the datapath.
// The master modport is the sequencer's view of the bundle.
interface control_sequencer_if #(
    parameter int CW_WIDTH     = 33,
    parameter int STATUS_WIDTH = 5
);
    logic [63:0]             data_bus;
    logic                    mem_ready;
    logic [CW_WIDTH-1:0]     cw_exec;
    logic [STATUS_WIDTH-1:0] status_in;
    logic [31:0]             I;
    logic [1:0]              state;
    logic [STATUS_WIDTH-1:0] status;
    logic [CW_WIDTH-1:0]     cw;
    logic                    ir_load;
    logic                    halted;

    modport master (
        input  data_bus, mem_ready, cw_exec, status_in,
        output I, state, status, cw, ir_load, halted
    );

    modport slave (
        output data_bus, mem_ready, cw_exec, status_in,
        input  I, state, status, cw, ir_load, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Control-unit front end: owns IR, control state, status and halt.
// Emits fetch/stall/NOP control words itself and forwards the decoder word during execute.
module control_sequencer #(
    parameter int         CW_WIDTH     = 33,
    parameter int         STATUS_WIDTH = 5,
    parameter logic [1:0] FETCH_STATE  = 2'b00
) (
    input logic                 clock,
    input logic                 reset,
    control_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_EXEC   = 2'b01,
        ST_MULTI2 = 2'b10,
        ST_MULTI3 = 2'b11
    } state_e;

    localparam state_e FETCH = state_e'(FETCH_STATE);

    // Field order: alu_en, alu_bs, alu_fs, rf_b_en, sa, sb, da, rf_w, ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, next_state
    localparam logic [CW_WIDTH-1:0] FETCH_CW = {1'b0, 1'b1, 5'h1f, 1'b0, 5'h1f, 5'h1f, 5'h1f,
                                                1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b01};
    localparam logic [CW_WIDTH-1:0] STALL_CW = {1'b0, 1'b1, 5'h1f, 1'b0, 5'h1f, 5'h1f, 5'h1f,
                                                1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [CW_WIDTH-1:0] NOP_CW   = {1'b0, 1'b1, 5'h1f, 1'b0, 5'h1f, 5'h1f, 5'h1f,
                                                1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};

    state_e                  state_q, state_d;
    logic [31:0]             i_q, i_d;
    logic [STATUS_WIDTH-1:0] status_q, status_d;
    logic                    halted_q, halted_d;
    logic [CW_WIDTH-1:0]     cw_c;
    logic                    ir_load_c;

    // Only the low word of the shared bus carries an instruction.
    logic unused_data_hi;
    assign unused_data_hi = ^bus.data_bus[63:32];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        i_d       = i_q;
        status_d  = status_q;
        halted_d  = halted_q;
        ir_load_c = 1'b0;
        cw_c      = bus.cw_exec;

        if (halted_q) begin
            cw_c    = NOP_CW;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (bus.mem_ready) begin
                cw_c      = FETCH_CW;
                ir_load_c = 1'b1;
                if (bus.data_bus[31:0] == 32'h0) begin
                    i_d      = 32'h0;
                    halted_d = 1'b1;
                end else begin
                    i_d     = bus.data_bus[31:0];
                    state_d = ST_EXEC;
                end
            end else begin
                cw_c = STALL_CW;
            end
        end else begin
            state_d = state_e'(bus.cw_exec[1:0]);
        end

        // Fetch, stall and NOP words all have status_ld clear, so only execute cycles land here.
        if (cw_c[2]) begin
            status_d = bus.status_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            i_q      <= '0;
            status_q <= '0;
            halted_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            i_q      <= i_d;
            status_q <= status_d;
            halted_q <= halted_d;
        end
    end

    assign bus.I       = i_q;
    assign bus.state   = state_q;
    assign bus.status  = status_q;
    assign bus.halted  = halted_q;
    assign bus.cw      = cw_c;
    assign bus.ir_load = ir_load_c;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a driver pushes model predictions, a monitor pops and compares.
// Directed scenarios come first, then randomized traffic with occasional halts and resets.
module tb_control_sequencer;
    typedef struct {
        string       tag;
        logic [32:0] cw;
        logic        ir_load;
        logic [1:0]  state;
        logic [31:0] i;
        logic [4:0]  status;
        logic        halted;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];

    logic [32:0] fetch_cw, stall_cw, nop_cw;

    // Reference model of the architectural registers.
    int          m_state;
    logic [31:0] m_i;
    logic [4:0]  m_status;
    bit          m_halted;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [32:0] mk_cw(bit ram_en, bit [1:0] pc_fs, bit [1:0] ns);
        logic [32:0] w;
        w          = '0;
        w[31]      = 1'b1;
        w[30:26]   = 5'h1f;
        w[24:20]   = 5'h1f;
        w[19:15]   = 5'h1f;
        w[14:10]   = 5'h1f;
        w[8]       = ram_en;
        w[5:4]     = pc_fs;
        w[1:0]     = ns;
        return w;
    endfunction

    function automatic logic [32:0] mk_exec(bit sld, bit [1:0] ns);
        logic [32:0] w;
        w[31:0] = $urandom;
        w[32]   = 1'($urandom_range(0, 1));
        w[2]    = sld;
        w[1:0]  = ns;
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_i      = '0;
        m_status = '0;
        m_halted = 0;
    endtask

    // One clock cycle: drive inputs, predict outputs for this cycle, then advance the model past the edge.
    task automatic cyc(input string tag, input bit mr, input logic [63:0] db,
                       input logic [32:0] ce, input logic [4:0] si);
        exp_t e;
        @(negedge clock);
        bus.mem_ready = mr;
        bus.data_bus  = db;
        bus.cw_exec   = ce;
        bus.status_in = si;
        #1;
        e.tag     = tag;
        e.state   = 2'(m_state);
        e.i       = m_i;
        e.status  = m_status;
        e.halted  = m_halted;
        e.ir_load = !m_halted && m_state == 0 && mr;
        if (m_halted)          e.cw = nop_cw;
        else if (m_state == 0) e.cw = mr ? fetch_cw : stall_cw;
        else                   e.cw = ce;
        exp_q.push_back(e);

        if (!m_halted) begin
            if (m_state == 0) begin
                if (mr) begin
                    if (db[31:0] == 32'h0) begin
                        m_i      = '0;
                        m_halted = 1;
                    end else begin
                        m_i     = db[31:0];
                        m_state = 1;
                    end
                end
            end else begin
                if (ce[2]) m_status = si;
                m_state = int'(ce[1:0]);
            end
        end
    endtask

    // Asserts reset mid-cycle (after the monitor has sampled) and checks that it acts with no clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, ".rst_state"},  64'(bus.state),  64'h0);
        check({tag, ".rst_I"},      64'(bus.I),      64'h0);
        check({tag, ".rst_status"}, 64'(bus.status), 64'h0);
        check({tag, ".rst_halted"}, 64'(bus.halted), 64'h0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: compares every prediction queued for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".cw"},      64'(bus.cw),      64'(e.cw));
                check({e.tag, ".ir_load"}, 64'(bus.ir_load), 64'(e.ir_load));
                check({e.tag, ".state"},   64'(bus.state),   64'(e.state));
                check({e.tag, ".I"},       64'(bus.I),       64'(e.i));
                check({e.tag, ".status"},  64'(bus.status),  64'(e.status));
                check({e.tag, ".halted"},  64'(bus.halted),  64'(e.halted));
            end
        end
    end

    initial begin
        logic [63:0] db;
        total    = 0;
        bad      = 0;
        fetch_cw = mk_cw(1'b1, 2'b01, 2'b01);
        stall_cw = mk_cw(1'b1, 2'b00, 2'b00);
        nop_cw   = mk_cw(1'b0, 2'b00, 2'b00);
        model_reset();

        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.data_bus  = '0;
        bus.cw_exec   = '0;
        bus.status_in = '0;
        #1;
        check("por.state",  64'(bus.state),  64'h0);
        check("por.I",      64'(bus.I),      64'h0);
        check("por.status", 64'(bus.status), 64'h0);
        check("por.halted", 64'(bus.halted), 64'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        // BL: fetch then one execute cycle, back to fetch.
        cyc("bl_fetch", 1'b1, 64'hdead_beef_9400_0010, mk_exec(1'b0, 2'b00), 5'h03);
        cyc("bl_exec",  1'b1, 64'h0000_0000_1111_2222, mk_exec(1'b0, 2'b00), 5'h03);
        cyc("bl_next",  1'b0, 64'h0, mk_exec(1'b0, 2'b00), 5'h00);

        // Mid-execute reset: no partial IR or status update.
        cyc("mx_fetch", 1'b1, 64'h0000_0000_8b02_0020, mk_exec(1'b1, 2'b00), 5'h1f);
        do_reset("mid_exec");

        // Three-cycle stall then load.
        for (int k = 0; k < 3; k++)
            cyc("stall", 1'b0, {$urandom, $urandom}, mk_exec(1'b1, 2'b01), 5'h15);
        cyc("stall_ld", 1'b1, 64'h0000_0000_8b02_0020, mk_exec(1'b1, 2'b01), 5'h15);

        // Status load in execute; fetch cycle does not disturb it.
        cyc("st_exec",  1'b1, 64'h0, mk_exec(1'b1, 2'b00), 5'b10110);
        cyc("st_fetch", 1'b1, 64'h0000_0000_b400_0040, mk_exec(1'b1, 2'b00), 5'b00001);
        cyc("st_exec2", 1'b0, 64'h0, mk_exec(1'b0, 2'b00), 5'b00001);

        // HALT fetch, then ten cycles with mem_ready toggling.
        cyc("halt", 1'b1, 64'hffff_ffff_0000_0000, mk_exec(1'b1, 2'b01), 5'h1f);
        for (int k = 0; k < 10; k++)
            cyc("halted", 1'(k % 2 == 0), {$urandom, $urandom}, mk_exec(1'b1, 2'b01), 5'h1f);
        do_reset("halt_clr");

        // Multi-cycle decoder path 01 -> 10 -> 11 -> 00, reset while in 10.
        cyc("mc_fetch", 1'b1, 64'h0000_0000_f840_0000, mk_exec(1'b0, 2'b10), 5'h0a);
        cyc("mc_s1",    1'b1, 64'h0, mk_exec(1'b0, 2'b10), 5'h0a);
        cyc("mc_s2",    1'b1, 64'h0, mk_exec(1'b0, 2'b11), 5'h0a);
        do_reset("mc_rst");
        cyc("mc_s1b",   1'b1, 64'h0000_0000_f840_0000, mk_exec(1'b0, 2'b10), 5'h0a);
        cyc("mc_s2b",   1'b1, 64'h0, mk_exec(1'b0, 2'b10), 5'h0a);
        cyc("mc_s3b",   1'b1, 64'h0, mk_exec(1'b0, 2'b11), 5'h0a);
        cyc("mc_s4b",   1'b1, 64'h0, mk_exec(1'b0, 2'b00), 5'h0a);
        cyc("mc_done",  1'b0, 64'h0, mk_exec(1'b0, 2'b00), 5'h0a);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            db = {$urandom, $urandom};
            if ($urandom_range(0, 29) == 0) db[31:0] = 32'h0;
            cyc("rnd", 1'($urandom_range(0, 3) != 0), db,
                mk_exec(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))), 5'($urandom));
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 59) == 0)
                do_reset("rnd_rst");
        end

        @(negedge clock);
        #3;
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control-unit front end that sits directly upstream of the per-opcode decoders (BL, branch, ALU, load/store).
- Owns the instruction register, the 2-bit control state and the 5-bit status register.
- Generates the fetch control word itself. In execute states it forwards the selected decoder's 33-bit control word and advances state from that word's next_state field.
- Feeds I, state and status to the decoders and drives the final control word to the datapath.

Parameters:
- CW_WIDTH, 33, control-word width. The field map below is fixed for 33.
- STATUS_WIDTH, 5, status/flag width.
- FETCH_STATE, 2'b00, encoding of the fetch state.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_bus  input  64  shared data bus; the fetched instruction is on bits [31:0].
- mem_ready  input  1  RAM read data valid this cycle.
- cw_exec  input  33  control word from the opcode-selected decoder.
- status_in  input  5  ALU flags.
- I  output  32  instruction register.
- state  output  2  current control state.
- status  output  5  registered status.
- cw  output  33  control word to the datapath.
- ir_load  output  1  high in the cycle the IR captures data_bus.
- halted  output  1  sticky halt indicator.

Behaviour:
- Control-word field map, MSB to LSB:
  - alu_en[32], alu_bs[31], alu_fs[30:26], rf_b_en[25]
  - rf_sa[24:20], rf_sb[19:15], rf_da[14:10], rf_w[9]
  - ram_en[8], ram_w[7], pc_en[6], pc_fs[5:4], pc_is[3]
  - status_ld[2], next_state[1:0]
- pc_fs encodings: 00 hold, 01 PC+4, 11 PC+4*in+4.
- Reset (reset low, asynchronous): state=00, I=0, status=0, halted=0. Outputs are valid immediately; the first cycle after deassertion is a fetch.
- FETCH_CW: alu_en 0, alu_bs 1, alu_fs 11111, rf_b_en 0, sa/sb/da 31, rf_w 0, ram_en 1, ram_w 0, pc_en 0, pc_fs 01, pc_is 0, status_ld 0, next_state 01.
- STALL_CW: FETCH_CW with pc_fs 00 and next_state 00.
- NOP_CW: all enables and writes 0, alu_bs 1, alu_fs 11111, sa/sb/da 31, pc_fs 00, next_state 00.
- cw is combinational from registered state:
  - halted=1 -> NOP_CW.
  - state=00 and mem_ready=1 -> FETCH_CW.
  - state=00 and mem_ready=0 -> STALL_CW.
  - state!=00 -> cw_exec unchanged.
- Fetch state (00):
  - mem_ready=0: hold state 00, I unchanged, ir_load=0. Stall length is unbounded.
  - mem_ready=1: ir_load=1.
    - data_bus[31:0]!=0: I <= data_bus[31:0] and state <= 01 at the clock edge.
    - data_bus[31:0]==0 (HALT): I <= 0, halted <= 1, state stays 00.
- Execute states (01, 10, 11): state <= cw_exec[1:0] each clock. 00 returns to fetch; 10/11 permit multi-cycle decoders. I is held throughout.
- Status: status <= status_in at the edge ending any cycle where cw[2]=1. Only execute cycles can set this bit. Otherwise status holds.
- halted is sticky until reset. While halted:
  - state is held at 00.
  - I, status and the PC (pc_fs 00) do not change.
  - ir_load=0.
  - mem_ready is ignored.
- Latency:
  - Fetch-to-execute is 1 cycle when mem_ready=1.
  - A single-cycle instruction (e.g. BL, next_state 00) takes exactly 2 cycles from fetch to the next fetch.
- Reset asserted mid-execute: immediate return to reset values with no partial status or IR update. Execution restarts from fetch.
- Illegal next_state is not possible. All four encodings are legal; 01 from an execute state simply re-enters 01.

Test Plan:
- Reset low mid-cycle -> state=00, I=0, status=0, halted=0 with no clock edge. First cycle after release: cw=FETCH_CW (bit8=1, pc_fs=01, next_state=01).
- Fetch with mem_ready=1, data_bus[31:0]=0x94000010 (BL +16), cw_exec next_state=00 -> ir_load=1 and I=0x94000010 after the edge, state=01. cw equals cw_exec for one cycle, then state=00 with cw=FETCH_CW again. Total 2 cycles.
- mem_ready held 0 for 3 cycles, then 1 -> cw=STALL_CW (pc_fs=00) and state=00 for 3 cycles with I unchanged. IR loads on cycle 4.
- Execute with cw_exec[2]=1, status_in=5'b10110 -> status=5'b10110 after the edge. A following fetch cycle with status_in=5'b00001 leaves status=5'b10110.
- Fetch of 0x00000000 -> halted=1 and cw=NOP_CW thereafter. Ten further cycles with mem_ready toggling leave state=00 and I=0. Reset clears halted.
- Multi-cycle: cw_exec next_state sequence 10, 11, 00 -> state goes 01, 10, 11, 00. Reset asserted while state=10 -> state=00 immediately and status unchanged from its reset value 0.
